// File: rtl/updown_sweep_ctrl.sv
// Sweep controller for an external up/down saturating counter.
// Each run clears the counter, then repeats SWEEPS times: ramp up to MAX,
// dwell, ramp down to 0, dwell. DONE pulses once at normal completion.
module updown_sweep_ctrl #(
  parameter int unsigned COUNTER_SIZE = 2,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned SWEEPS       = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [COUNTER_SIZE-1:0] COUNT_IN,
  output logic                    CNT_EN,
  output logic                    CNT_UP,
  output logic                    CNT_CLR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [3:0]              SWEEP_CNT
);

  localparam logic [COUNTER_SIZE-1:0] CountMax = '1;
  localparam logic [COUNTER_SIZE-1:0] CountMin = '0;
  localparam bit                      HoldSkip = (HOLD_CYCLES == 0);
  // Hold counter counts down to 0 inclusive, so load one less than the dwell.
  localparam logic [7:0] HoldLoad    = HoldSkip ? 8'd0 : 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] SweepsTotal = 4'(SWEEPS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRampUp,
    StHoldHi,
    StRampDn,
    StHoldLo,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] sweep_q, sweep_d;
  logic [3:0] sweep_inc;
  logic       sweep_end;
  logic       en_d, up_d, clr_d, busy_d, done_d;

  assign sweep_inc = sweep_q + 4'd1;
  assign SWEEP_CNT = sweep_q;

  // Next-state, hold timer and sweep counter; ABORT overrides normal flow.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sweep_d   = sweep_q;
    sweep_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) state_d = StClear;
      end
      StClear: begin
        state_d = StRampUp;
        sweep_d = '0;
      end
      StRampUp: begin
        if (COUNT_IN == CountMax) begin
          if (HoldSkip) begin
            state_d = StRampDn;
          end else begin
            state_d = StHoldHi;
            hold_d  = HoldLoad;
          end
        end
      end
      StHoldHi: begin
        if (hold_q == 8'd0) state_d = StRampDn;
        else                hold_d  = hold_q - 8'd1;
      end
      StRampDn: begin
        if (COUNT_IN == CountMin) begin
          if (HoldSkip) begin
            sweep_end = 1'b1;
          end else begin
            state_d = StHoldLo;
            hold_d  = HoldLoad;
          end
        end
      end
      StHoldLo: begin
        if (hold_q == 8'd0) sweep_end = 1'b1;
        else                hold_d    = hold_q - 8'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Next sweep restarts at RAMP_UP directly: the counter already sits at 0.
    if (sweep_end) begin
      sweep_d = sweep_inc;
      state_d = (sweep_inc == SweepsTotal) ? StDone : StRampUp;
    end

    if (ABORT && (state_q != StIdle) && (state_q != StDone)) begin
      state_d = StIdle;
      hold_d  = '0;
      sweep_d = sweep_q;
    end
  end

  // Output decode of the upcoming state, so registered outputs track state_q.
  always_comb begin
    en_d   = 1'b0;
    up_d   = 1'b0;
    clr_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StClear:  begin clr_d = 1'b1; busy_d = 1'b1; end
      StRampUp: begin en_d  = 1'b1; up_d   = 1'b1; busy_d = 1'b1; end
      StHoldHi: begin up_d  = 1'b1; busy_d = 1'b1; end
      StRampDn: begin en_d  = 1'b1; busy_d = 1'b1; end
      StHoldLo: begin busy_d = 1'b1; end
      StDone:   begin done_d = 1'b1; end
      default:  begin end
    endcase
  end

  // State, timers and registered Moore outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      hold_q  <= '0;
      sweep_q <= '0;
      CNT_EN  <= 1'b0;
      CNT_UP  <= 1'b0;
      CNT_CLR <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sweep_q <= sweep_d;
      CNT_EN  <= en_d;
      CNT_UP  <= up_d;
      CNT_CLR <= clr_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter COUNTER_SIZE, default 2: width of the controlled counter's COUNT; MAX = 2^COUNTER_SIZE-1.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4: dwell length at each saturation point, legal range 0..255.
REQ-003 The block SHALL have parameter SWEEPS, default 2: number of up/down sweeps per run, legal range 1..15.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port START, input, 1 bit: one-cycle request to begin a run; sampled only in IDLE.
REQ-007 The block SHALL have port ABORT, input, 1 bit: terminates a run in progress.
REQ-008 The block SHALL have port COUNT_IN, input, COUNTER_SIZE bits: registered COUNT from the up/down saturating counter.
REQ-009 The block SHALL have port CNT_EN, output, 1 bit: drives the counter's EN.
REQ-010 The block SHALL have port CNT_UP, output, 1 bit: drives the counter's UP_DWN; 1 = up, 0 = down.
REQ-011 The block SHALL have port CNT_CLR, output, 1 bit: synchronous clear to the counter; the counter reads 0 on the edge after CNT_CLR=1.
REQ-012 The block SHALL have port BUSY, output, 1 bit: a run is in progress.
REQ-013 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at normal run completion.
REQ-014 The block SHALL have port SWEEP_CNT, output, 4 bits: number of completed sweeps in the current or last run.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, RAMP_UP, HOLD_HI, RAMP_DN, HOLD_LO, DONE.
REQ-016 All outputs SHALL be Moore, decoded from the registered state: no combinational path from any input to any output.
REQ-017 Outputs per state SHALL be: IDLE all 0; CLEAR CNT_CLR=1, BUSY=1; RAMP_UP CNT_EN=1, CNT_UP=1, BUSY=1; HOLD_HI CNT_UP=1, BUSY=1; RAMP_DN CNT_EN=1, CNT_UP=0, BUSY=1; HOLD_LO BUSY=1; DONE DONE=1.
REQ-018 IDLE->CLEAR SHALL occur when START=1; CLEAR->RAMP_UP SHALL occur unconditionally, and SWEEP_CNT SHALL clear to 0 on this transition.
REQ-019 RAMP_UP->HOLD_HI SHALL occur when COUNT_IN==MAX; otherwise the FSM stays in RAMP_UP.
REQ-020 RAMP_DN->HOLD_LO SHALL occur when COUNT_IN==0; otherwise the FSM stays in RAMP_DN.
REQ-021 Each hold state SHALL last exactly HOLD_CYCLES cycles, timed by an 8-bit down-counter loaded on entry; with HOLD_CYCLES=0 the hold state SHALL be skipped: RAMP_UP->RAMP_DN and RAMP_DN->sweep-end directly.
REQ-022 At sweep end, on leaving HOLD_LO or RAMP_DN per REQ-021, SWEEP_CNT SHALL increment; if the new value equals SWEEPS the FSM SHALL go to DONE, else to RAMP_UP without a CLEAR.
REQ-023 DONE->IDLE SHALL occur unconditionally, so DONE is high for exactly one cycle.
REQ-024 ABORT=1 in any state other than IDLE or DONE SHALL force IDLE on the next edge, with no DONE pulse and SWEEP_CNT holding its value; ABORT in IDLE or DONE SHALL have no effect.
REQ-025 Priority SHALL be RST > ABORT > START/normal transitions; START while BUSY=1 or in DONE SHALL be ignored, and simultaneous START and ABORT in IDLE SHALL start a run.
REQ-026 The extra enabled cycle at saturation (CNT_EN=1 while COUNT_IN==MAX or 0) is intended; the saturating counter holds its value.
REQ-027 With default parameters, a run from START to DONE SHALL take 1 (CLEAR) + SWEEPS x (4+4+4+4) cycles = 33 cycles, followed by 1 cycle in DONE.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, clear the hold counter, and clear SWEEP_CNT=0 from any state, including mid-ramp and mid-hold.
REQ-029 During RST all outputs SHALL be 0 from the first edge at which RST is sampled high, and the block SHALL accept START on the first edge after RST deasserts.

Verification (defaults; counter model is a 2-bit saturating up/down counter with EN and synchronous clear)
REQ-030 The bench SHALL cover a normal run: START pulse in IDLE -> CNT_CLR high 1 cycle; COUNT sequence 0,1,2,3 (hold 4 cycles) 3,2,1,0 (hold 4 cycles) twice; DONE pulses once 34 cycles after START; SWEEP_CNT=2; BUSY low in DONE and IDLE.
REQ-031 The bench SHALL cover abort mid-run: ABORT during the 2nd HOLD_HI -> next cycle IDLE, all outputs 0, SWEEP_CNT=1, no DONE pulse.
REQ-032 The bench SHALL cover reset mid-run: RST asserted during RAMP_DN with COUNT_IN=2 -> next cycle IDLE, SWEEP_CNT=0; START after RST release begins a fresh run with CNT_CLR.
REQ-033 The bench SHALL cover START ignored while busy: START pulses during RAMP_UP and during DONE -> no state change, and exactly one DONE per run.
REQ-034 The bench SHALL cover HOLD_CYCLES=0 with SWEEPS=1: COUNT 0,1,2,3,3,2,1,0 with no dwell, and DONE pulses 9 cycles after START.
REQ-035 The bench SHALL cover simultaneous START and ABORT in IDLE: the run starts and CLEAR is entered.
